// File: rtl/dispatcher_pkg.sv
// Shared constants for the dispatch stage: field widths, opcode encodings,
// the x0 index and the holding-register state encoding.
package dispatcher_pkg;

  localparam int ROB_ID_W_DEF = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int OP_W_DEF     = 6;
  localparam int REG_W        = 5;

  localparam logic [REG_W-1:0] REG_X0 = '0;

  localparam logic [OP_W_DEF-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W_DEF-1:0] OP_ADDI = 6'd2;
  localparam logic [OP_W_DEF-1:0] OP_LW   = 6'd3;
  localparam logic [OP_W_DEF-1:0] OP_SW   = 6'd4;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } dsp_state_e;

  function automatic logic is_x0(input logic [REG_W-1:0] idx);
    return idx == REG_X0;
  endfunction

endpackage

// File: rtl/dsp_operand_resolve.sv
// Combinational source-operand resolution: RF, then ROB, then CDB.
// DSP_CDB_BYPASS_EN selects forwarding a CDB match versus stalling on it.
module dsp_operand_resolve
  import dispatcher_pkg::*;
#(
  parameter int ROB_ID_W = ROB_ID_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                use_src,
  input  logic [REG_W-1:0]    idx,
  input  logic                rf_busy,
  input  logic [ROB_ID_W-1:0] rf_tag,
  input  logic [DATA_W-1:0]   rf_val,
  input  logic                rob_rdy,
  input  logic [DATA_W-1:0]   rob_v,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_tag,
  input  logic [DATA_W-1:0]   cdb_val,
  output logic                ready,
  output logic [ROB_ID_W-1:0] q,
  output logic [DATA_W-1:0]   v,
  output logic                stall
);

  always_comb begin
    ready = 1'b1;
    q     = '0;
    v     = '0;
    stall = 1'b0;
    if (!use_src || is_x0(idx)) begin
      ready = 1'b1;
    end else if (!rf_busy) begin
      v = rf_val;
    end else if (rob_rdy) begin
      v = rob_v;
    end else if (cdb_valid && (cdb_tag == rf_tag)) begin
`ifdef DSP_CDB_BYPASS_EN
      v = cdb_val;
`else
      // Value is discarded: the stall blocks issue and the retry reads the ROB.
      ready = 1'b0;
      q     = rf_tag;
      v     = cdb_val;
      stall = 1'b1;
`endif
    end else begin
      ready = 1'b0;
      q     = rf_tag;
    end
  end

endmodule

// File: rtl/dispatcher.sv
// Issue stage: one-entry holding register, operand resolution, ROB allocation,
// rename and issue to RS/LSB. Optional macro: DSP_CDB_BYPASS_EN.
module dispatcher
  import dispatcher_pkg::*;
#(
  parameter int ROB_ID_W = ROB_ID_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int OP_W     = OP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clr,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [OP_W-1:0]     dec_op,
  input  logic [4:0]          dec_rd,
  input  logic [4:0]          dec_rs1,
  input  logic [4:0]          dec_rs2,
  input  logic                dec_use_rs1,
  input  logic                dec_use_rs2,
  input  logic                dec_has_rd,
  input  logic                dec_is_ls,
  input  logic [DATA_W-1:0]   dec_imm,
  input  logic [DATA_W-1:0]   dec_pc,
  output logic [4:0]          rf_rs1,
  output logic [4:0]          rf_rs2,
  input  logic                rf_busy1,
  input  logic                rf_busy2,
  input  logic [ROB_ID_W-1:0] rf_tag1,
  input  logic [ROB_ID_W-1:0] rf_tag2,
  input  logic [DATA_W-1:0]   rf_val1,
  input  logic [DATA_W-1:0]   rf_val2,
  output logic                rf_ren_en,
  output logic [4:0]          rf_ren_rd,
  output logic [ROB_ID_W-1:0] rf_ren_tag,
  input  logic                rob_full,
  input  logic [ROB_ID_W-1:0] rob_id,
  output logic [ROB_ID_W-1:0] rob_qi,
  output logic [ROB_ID_W-1:0] rob_qj,
  input  logic                rob_qi_rdy,
  input  logic                rob_qj_rdy,
  input  logic [DATA_W-1:0]   rob_vi,
  input  logic [DATA_W-1:0]   rob_vj,
  output logic                rob_alloc,
  output logic [4:0]          rob_rd,
  output logic [OP_W-1:0]     rob_op,
  output logic [DATA_W-1:0]   rob_pc,
  input  logic                rs_full,
  input  logic                lsb_full,
  output logic                rs_en,
  output logic                lsb_en,
  output logic [OP_W-1:0]     iss_op,
  output logic [ROB_ID_W-1:0] iss_qi,
  output logic [ROB_ID_W-1:0] iss_qj,
  output logic [DATA_W-1:0]   iss_vi,
  output logic [DATA_W-1:0]   iss_vj,
  output logic                iss_ri,
  output logic                iss_rj,
  output logic [DATA_W-1:0]   iss_imm,
  output logic [DATA_W-1:0]   iss_pc,
  output logic [ROB_ID_W-1:0] iss_tag,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_tag,
  input  logic [DATA_W-1:0]   cdb_val
);

  dsp_state_e state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [4:0]          rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic                use1_q, use1_d, use2_q, use2_d, has_rd_q, has_rd_d, is_ls_q, is_ls_d;
  logic [DATA_W-1:0]   imm_q, imm_d, pc_q, pc_d;

  logic                rob_alloc_q, rob_alloc_d, rs_en_q, rs_en_d, lsb_en_q, lsb_en_d;
  logic                rf_ren_en_q, rf_ren_en_d;
  logic [4:0]          rob_rd_q, rob_rd_d, rf_ren_rd_q, rf_ren_rd_d;
  logic [OP_W-1:0]     rob_op_q, rob_op_d, iss_op_q, iss_op_d;
  logic [DATA_W-1:0]   rob_pc_q, rob_pc_d, iss_pc_q, iss_pc_d, iss_imm_q, iss_imm_d;
  logic [DATA_W-1:0]   iss_vi_q, iss_vi_d, iss_vj_q, iss_vj_d;
  logic [ROB_ID_W-1:0] rf_ren_tag_q, rf_ren_tag_d, iss_tag_q, iss_tag_d;
  logic [ROB_ID_W-1:0] iss_qi_q, iss_qi_d, iss_qj_q, iss_qj_d;
  logic                iss_ri_q, iss_ri_d, iss_rj_q, iss_rj_d;

  logic                ready1, ready2, stall1, stall2;
  logic [ROB_ID_W-1:0] q1, q2;
  logic [DATA_W-1:0]   v1, v2;
  logic                held, unit_full, go, accept, strobe_gate;

  dsp_operand_resolve #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_res1 (
    .use_src(use1_q), .idx(rs1_q), .rf_busy(rf_busy1), .rf_tag(rf_tag1), .rf_val(rf_val1),
    .rob_rdy(rob_qi_rdy), .rob_v(rob_vi), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .ready(ready1), .q(q1), .v(v1), .stall(stall1)
  );

  dsp_operand_resolve #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_res2 (
    .use_src(use2_q), .idx(rs2_q), .rf_busy(rf_busy2), .rf_tag(rf_tag2), .rf_val(rf_val2),
    .rob_rdy(rob_qj_rdy), .rob_v(rob_vj), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .ready(ready2), .q(q2), .v(v2), .stall(stall2)
  );

  assign held       = (state_q == HELD);
  assign unit_full  = is_ls_q ? lsb_full : rs_full;
  assign go         = rdy && !clr && held && !rob_full && !unit_full && !stall1 && !stall2;
  assign inst_ready = !rst && rdy && !clr && (!held || go);
  assign accept     = inst_ready && inst_valid;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;     rd_d     = rd_q;     rs1_d    = rs1_q;   rs2_d = rs2_q;
    use1_d   = use1_q;   use2_d   = use2_q;   has_rd_d = has_rd_q; is_ls_d = is_ls_q;
    imm_d    = imm_q;    pc_d     = pc_q;
    if (rdy) begin
      if (clr) begin
        state_d = EMPTY;
      end else if (accept) begin
        state_d  = HELD;
        op_d     = dec_op;      rd_d     = dec_rd;      rs1_d    = dec_rs1;    rs2_d   = dec_rs2;
        use1_d   = dec_use_rs1; use2_d   = dec_use_rs2; has_rd_d = dec_has_rd; is_ls_d = dec_is_ls;
        imm_d    = dec_imm;     pc_d     = dec_pc;
      end else if (go) begin
        state_d = EMPTY;
      end
    end
  end

  // Strobes follow go only while enabled; the issue bus holds between issues.
  always_comb begin
    rob_alloc_d  = rob_alloc_q;  rs_en_d   = rs_en_q;   lsb_en_d    = lsb_en_q;
    rf_ren_en_d  = rf_ren_en_q;
    rob_rd_d     = rob_rd_q;     rob_op_d  = rob_op_q;  rob_pc_d    = rob_pc_q;
    rf_ren_rd_d  = rf_ren_rd_q;  rf_ren_tag_d = rf_ren_tag_q;
    iss_op_d     = iss_op_q;     iss_qi_d  = iss_qi_q;  iss_qj_d    = iss_qj_q;
    iss_vi_d     = iss_vi_q;     iss_vj_d  = iss_vj_q;  iss_ri_d    = iss_ri_q;
    iss_rj_d     = iss_rj_q;     iss_imm_d = iss_imm_q; iss_pc_d    = iss_pc_q;
    iss_tag_d    = iss_tag_q;
    if (rdy) begin
      rob_alloc_d = go;
      rs_en_d     = go && !is_ls_q;
      lsb_en_d    = go && is_ls_q;
      rf_ren_en_d = go && has_rd_q && !is_x0(rd_q);
    end
    if (go) begin
      rob_rd_d     = has_rd_q ? rd_q : REG_X0;
      rob_op_d     = op_q;
      rob_pc_d     = pc_q;
      rf_ren_rd_d  = rd_q;
      rf_ren_tag_d = rob_id;
      iss_op_d     = op_q;
      iss_qi_d     = q1;     iss_qj_d = q2;
      iss_vi_d     = v1;     iss_vj_d = v2;
      iss_ri_d     = ready1; iss_rj_d = ready2;
      iss_imm_d    = imm_q;  iss_pc_d = pc_q;
      iss_tag_d    = rob_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      op_q     <= '0; rd_q <= '0; rs1_q <= '0; rs2_q <= '0;
      use1_q   <= 1'b0; use2_q <= 1'b0; has_rd_q <= 1'b0; is_ls_q <= 1'b0;
      imm_q    <= '0; pc_q <= '0;
      rob_alloc_q  <= 1'b0; rs_en_q <= 1'b0; lsb_en_q <= 1'b0; rf_ren_en_q <= 1'b0;
      rob_rd_q     <= '0; rob_op_q <= '0; rob_pc_q <= '0;
      rf_ren_rd_q  <= '0; rf_ren_tag_q <= '0;
      iss_op_q     <= '0; iss_qi_q <= '0; iss_qj_q <= '0; iss_vi_q <= '0; iss_vj_q <= '0;
      iss_ri_q     <= 1'b0; iss_rj_q <= 1'b0; iss_imm_q <= '0; iss_pc_q <= '0; iss_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d; rd_q <= rd_d; rs1_q <= rs1_d; rs2_q <= rs2_d;
      use1_q   <= use1_d; use2_q <= use2_d; has_rd_q <= has_rd_d; is_ls_q <= is_ls_d;
      imm_q    <= imm_d; pc_q <= pc_d;
      rob_alloc_q  <= rob_alloc_d; rs_en_q <= rs_en_d; lsb_en_q <= lsb_en_d; rf_ren_en_q <= rf_ren_en_d;
      rob_rd_q     <= rob_rd_d; rob_op_q <= rob_op_d; rob_pc_q <= rob_pc_d;
      rf_ren_rd_q  <= rf_ren_rd_d; rf_ren_tag_q <= rf_ren_tag_d;
      iss_op_q     <= iss_op_d; iss_qi_q <= iss_qi_d; iss_qj_q <= iss_qj_d;
      iss_vi_q     <= iss_vi_d; iss_vj_q <= iss_vj_d;
      iss_ri_q     <= iss_ri_d; iss_rj_q <= iss_rj_d; iss_imm_q <= iss_imm_d;
      iss_pc_q     <= iss_pc_d; iss_tag_q <= iss_tag_d;
    end
  end

  // A strobe held over a pause is shown only once rdy returns.
  assign strobe_gate = rdy && !rst;
  assign rob_alloc   = rob_alloc_q && strobe_gate;
  assign rs_en       = rs_en_q && strobe_gate;
  assign lsb_en      = lsb_en_q && strobe_gate;
  assign rf_ren_en   = rf_ren_en_q && strobe_gate;

  assign rf_rs1     = rs1_q;
  assign rf_rs2     = rs2_q;
  assign rob_qi     = rf_tag1;
  assign rob_qj     = rf_tag2;
  assign rob_rd     = rob_rd_q;
  assign rob_op     = rob_op_q;
  assign rob_pc     = rob_pc_q;
  assign rf_ren_rd  = rf_ren_rd_q;
  assign rf_ren_tag = rf_ren_tag_q;
  assign iss_op     = iss_op_q;
  assign iss_qi     = iss_qi_q;
  assign iss_qj     = iss_qj_q;
  assign iss_vi     = iss_vi_q;
  assign iss_vj     = iss_vj_q;
  assign iss_ri     = iss_ri_q;
  assign iss_rj     = iss_rj_q;
  assign iss_imm    = iss_imm_q;
  assign iss_pc     = iss_pc_q;
  assign iss_tag    = iss_tag_q;

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for dispatcher: issue latency, dependencies, CDB match,
// LSB back-pressure, flush and pause.
module tb_dispatcher;
  import dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, inst_valid, inst_ready;
  logic [5:0]  dec_op;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_use_rs1, dec_use_rs2, dec_has_rd, dec_is_ls;
  logic [31:0] dec_imm, dec_pc;
  logic [4:0]  rf_rs1, rf_rs2;
  logic        rf_busy1, rf_busy2;
  logic [3:0]  rf_tag1, rf_tag2;
  logic [31:0] rf_val1, rf_val2;
  logic        rf_ren_en;
  logic [4:0]  rf_ren_rd;
  logic [3:0]  rf_ren_tag;
  logic        rob_full;
  logic [3:0]  rob_id, rob_qi, rob_qj;
  logic        rob_qi_rdy, rob_qj_rdy;
  logic [31:0] rob_vi, rob_vj;
  logic        rob_alloc;
  logic [4:0]  rob_rd;
  logic [5:0]  rob_op;
  logic [31:0] rob_pc;
  logic        rs_full, lsb_full, rs_en, lsb_en;
  logic [5:0]  iss_op;
  logic [3:0]  iss_qi, iss_qj, iss_tag;
  logic [31:0] iss_vi, iss_vj, iss_imm, iss_pc;
  logic        iss_ri, iss_rj;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_has_rd(dec_has_rd),
    .dec_is_ls(dec_is_ls), .dec_imm(dec_imm), .dec_pc(dec_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_busy1(rf_busy1), .rf_busy2(rf_busy2),
    .rf_tag1(rf_tag1), .rf_tag2(rf_tag2), .rf_val1(rf_val1), .rf_val2(rf_val2),
    .rf_ren_en(rf_ren_en), .rf_ren_rd(rf_ren_rd), .rf_ren_tag(rf_ren_tag),
    .rob_full(rob_full), .rob_id(rob_id), .rob_qi(rob_qi), .rob_qj(rob_qj),
    .rob_qi_rdy(rob_qi_rdy), .rob_qj_rdy(rob_qj_rdy), .rob_vi(rob_vi), .rob_vj(rob_vj),
    .rob_alloc(rob_alloc), .rob_rd(rob_rd), .rob_op(rob_op), .rob_pc(rob_pc),
    .rs_full(rs_full), .lsb_full(lsb_full), .rs_en(rs_en), .lsb_en(lsb_en),
    .iss_op(iss_op), .iss_qi(iss_qi), .iss_qj(iss_qj), .iss_vi(iss_vi), .iss_vj(iss_vj),
    .iss_ri(iss_ri), .iss_rj(iss_rj), .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_tag(iss_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inst(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic u1, input logic u2,
                            input logic hrd, input logic ls, input logic [31:0] imm,
                            input logic [31:0] pc);
    inst_valid = 1'b1; dec_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_has_rd = hrd; dec_is_ls = ls;
    dec_imm = imm; dec_pc = pc;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; inst_valid = 1'b0;
    dec_op = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_has_rd = 1'b0; dec_is_ls = 1'b0;
    dec_imm = '0; dec_pc = '0;
    rf_busy1 = 1'b0; rf_busy2 = 1'b0; rf_tag1 = '0; rf_tag2 = '0; rf_val1 = '0; rf_val2 = '0;
    rob_full = 1'b0; rob_id = '0; rob_qi_rdy = 1'b0; rob_qj_rdy = 1'b0; rob_vi = '0; rob_vj = '0;
    rs_full = 1'b0; lsb_full = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;

    // Reset
    step(); step();
    check_eq("rst_inst_ready", inst_ready, 0);
    check_eq("rst_rob_alloc", rob_alloc, 0);
    check_eq("rst_iss_tag", iss_tag, 0);
    check_eq("rst_rf_ren_rd", rf_ren_rd, 0);
    rst = 1'b0;
    #1 check_eq("empty_inst_ready", inst_ready, 1);
    $display("txn reset done");

    // ADDI x1,x0,5 with rob_id=3
    rob_id = 4'd3;
    drive_inst(OP_ADDI, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'h100);
    step(); inst_valid = 1'b0;
    step();
    check_eq("addi_rob_alloc", rob_alloc, 1);
    check_eq("addi_rs_en", rs_en, 1);
    check_eq("addi_lsb_en", lsb_en, 0);
    check_eq("addi_iss_ri", iss_ri, 1);
    check_eq("addi_iss_vi", iss_vi, 0);
    check_eq("addi_iss_imm", iss_imm, 5);
    check_eq("addi_iss_tag", iss_tag, 3);
    check_eq("addi_rf_ren_en", rf_ren_en, 1);
    check_eq("addi_rf_ren_rd", rf_ren_rd, 1);
    check_eq("addi_rf_ren_tag", rf_ren_tag, 3);
    check_eq("addi_rob_pc", rob_pc, 32'h100);
    step();
    check_eq("addi_strobe_once", rob_alloc, 0);
    $display("txn ADDI x1,x0,5 tag=%0d imm=%0d", iss_tag, iss_imm);

    // ADD x2,x1,x1 with x1 pending on tag 3
    rob_id = 4'd4; rf_busy1 = 1'b1; rf_busy2 = 1'b1; rf_tag1 = 4'd3; rf_tag2 = 4'd3;
    drive_inst(OP_ADD, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'h104);
    step(); inst_valid = 1'b0;
    #1 check_eq("add_rob_qi", rob_qi, 3);
    step();
    check_eq("add_rs_en", rs_en, 1);
    check_eq("add_iss_ri", iss_ri, 0);
    check_eq("add_iss_rj", iss_rj, 0);
    check_eq("add_iss_qi", iss_qi, 3);
    check_eq("add_iss_qj", iss_qj, 3);
    check_eq("add_iss_tag", iss_tag, 4);
    step();
    $display("txn ADD x2,x1,x1 dependent tag=%0d qi=%0d", iss_tag, iss_qi);

    // Same dependency with CDB broadcasting tag 3 in the resolve cycle
    rob_id = 4'd5; rob_vi = 32'h2A; rob_vj = 32'h2A;
    drive_inst(OP_ADD, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'h108);
    step(); inst_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_val = 32'h2A;
`ifndef DSP_CDB_BYPASS_EN
    #1 check_eq("cdb_stall_inst_ready", inst_ready, 0);
`endif
    step();
    cdb_valid = 1'b0; rob_qi_rdy = 1'b1; rob_qj_rdy = 1'b1;
`ifdef DSP_CDB_BYPASS_EN
    check_eq("cdb_byp_rs_en", rs_en, 1);
`else
    check_eq("cdb_stall_rs_en", rs_en, 0);
    step();
    check_eq("cdb_retry_rs_en", rs_en, 1);
`endif
    check_eq("cdb_iss_ri", iss_ri, 1);
    check_eq("cdb_iss_rj", iss_rj, 1);
    check_eq("cdb_iss_vi", iss_vi, 32'h2A);
    check_eq("cdb_iss_vj", iss_vj, 32'h2A);
    check_eq("cdb_iss_tag", iss_tag, 5);
    step();
    rf_busy1 = 1'b0; rf_busy2 = 1'b0; rob_qi_rdy = 1'b0; rob_qj_rdy = 1'b0;
    $display("txn ADD x2,x1,x1 cdb match vi=0x%0h", iss_vi);

    // LW x5,8(x2) with LSB full for three cycles
    rob_id = 4'd6; rf_val1 = 32'h1000; lsb_full = 1'b1;
    drive_inst(OP_LW, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd8, 32'h10C);
    step(); inst_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("lw_full_lsb_en", lsb_en, 0);
      check_eq("lw_full_inst_ready", inst_ready, 0);
      step();
    end
    lsb_full = 1'b0;
    #1 check_eq("lw_free_inst_ready", inst_ready, 1);
    step();
    check_eq("lw_lsb_en", lsb_en, 1);
    check_eq("lw_rs_en", rs_en, 0);
    check_eq("lw_iss_vi", iss_vi, 32'h1000);
    check_eq("lw_iss_imm", iss_imm, 8);
    check_eq("lw_iss_tag", iss_tag, 6);
    step();
    $display("txn LW x5,8(x2) tag=%0d base=0x%0h", iss_tag, iss_vi);

    // Flush while HELD, then accept on the following cycle
    rob_id = 4'd7;
    drive_inst(OP_ADDI, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'h110);
    step(); inst_valid = 1'b0;
    clr = 1'b1;
    #1 check_eq("clr_inst_ready", inst_ready, 0);
    step(); clr = 1'b0;
    check_eq("clr_rob_alloc", rob_alloc, 0);
    check_eq("clr_rs_en", rs_en, 0);
    rob_id = 4'd8;
    drive_inst(OP_ADDI, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 32'h114);
    #1 check_eq("post_clr_inst_ready", inst_ready, 1);
    step(); inst_valid = 1'b0;
    step();
    check_eq("post_clr_rob_alloc", rob_alloc, 1);
    check_eq("post_clr_iss_tag", iss_tag, 8);
    check_eq("post_clr_iss_imm", iss_imm, 2);
    step();
    $display("txn flush then ADDI x3 tag=%0d", iss_tag);

    // Pause for two cycles while the strobe is pending
    rob_id = 4'd9;
    drive_inst(OP_ADDI, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd9, 32'h118);
    step(); inst_valid = 1'b0;
    step();
    rdy = 1'b0;
    #1 check_eq("pause_rob_alloc_0", rob_alloc, 0);
    check_eq("pause_inst_ready", inst_ready, 0);
    step();
    check_eq("pause_rob_alloc_1", rob_alloc, 0);
    check_eq("pause_iss_imm", iss_imm, 9);
    step();
    rdy = 1'b1;
    #1 check_eq("resume_rob_alloc", rob_alloc, 1);
    check_eq("resume_iss_tag", iss_tag, 9);
    step();
    check_eq("resume_no_dup", rob_alloc, 0);
    $display("txn pause/resume ADDI x4 tag=%0d", iss_tag);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
